// File: rtl/bus_rw_ctrl_if.sv
// CPU-strobe / buffer-control bundle between the bus sequencer and its neighbours.
// Access handshake: the CPU asserts CS_n low, then exactly one of RD_n or WR_n low,
// with A stable, and holds them until it releases the strobe. The controller answers
// with WR/IRD/IWR/RD and the register strobes, and raises busy from the first access
// state until its turnaround has finished. A new access needs a fresh falling strobe
// edge seen while busy is low.
interface bus_rw_ctrl_if;
  logic       CS_n;
  logic       RD_n;
  logic       WR_n;
  logic [1:0] A;
  logic       WR;
  logic       IRD;
  logic       IWR;
  logic       RD;
  logic [1:0] reg_sel;
  logic       reg_wr_en;
  logic       reg_rd_en;
  logic       busy;
  logic       err_conflict;
  logic       err_timeout;

  modport slave (
    input  CS_n, RD_n, WR_n, A,
    output WR, IRD, IWR, RD, reg_sel, reg_wr_en, reg_rd_en, busy, err_conflict, err_timeout
  );

  modport master (
    output CS_n, RD_n, WR_n, A,
    input  WR, IRD, IWR, RD, reg_sel, reg_wr_en, reg_rd_en, busy, err_conflict, err_timeout
  );
endinterface

// File: rtl/bus_rw_ctrl.sv
// Read/write sequencer for the 8-bit bidirectional bus buffer: synchronises the CPU
// strobes, runs the access FSM and drives registered (Moore) buffer/register controls.
module bus_rw_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int TA_CYCLES   = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic             CLK,
  input  logic             RST,
  bus_rw_ctrl_if.slave     bus,
  output logic [2:0]       dbg_state_o
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_W_LATCH  = 3'd1;
  localparam logic [2:0] S_W_PUSH   = 3'd2;
  localparam logic [2:0] S_WAIT_REL = 3'd3;
  localparam logic [2:0] S_R_FETCH  = 3'd4;
  localparam logic [2:0] S_R_DRIVE  = 3'd5;
  localparam logic [2:0] S_TURN     = 3'd6;

  localparam logic [1:0] FILL_LAST = 2'(SYNC_STAGES);
  localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [3:0] TA_LAST   = 4'(TA_CYCLES - 1);

  logic [SYNC_STAGES-1:0] cs_sync_q, rd_sync_q, wr_sync_q;
  logic [1:0]             a_sync_q [SYNC_STAGES];
  logic [1:0]             fill_q;
  logic                   rd_hist_q, wr_hist_q;

  logic       cs_s, rd_s, wr_s;
  logic [1:0] a_s;
  logic       fill_done, rd_act, wr_act, rd_start, wr_start;

  logic [2:0] state_q, state_d;
  logic [7:0] tmo_q, tmo_d;
  logic [3:0] ta_q, ta_d;
  logic [1:0] sel_q, sel_d;
  logic       conflict_d, timeout_d;

  logic wr_q, ird_q, iwr_q, rd_q, reg_wr_en_q, reg_rd_en_q, busy_q;
  logic err_conflict_q, err_timeout_q;

  assign cs_s = cs_sync_q[SYNC_STAGES-1];
  assign rd_s = rd_sync_q[SYNC_STAGES-1];
  assign wr_s = wr_sync_q[SYNC_STAGES-1];
  assign a_s  = a_sync_q[SYNC_STAGES-1];

  assign rd_act    = !cs_s && !rd_s;
  assign wr_act    = !cs_s && !wr_s;
  assign fill_done = (fill_q == FILL_LAST);
  assign rd_start  = rd_act && !rd_hist_q;
  assign wr_start  = wr_act && !wr_hist_q;

  // Until the synchronisers hold real samples the history reads "active", so a strobe
  // already low across reset never looks like a fresh falling edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cs_sync_q <= '1;
      rd_sync_q <= '1;
      wr_sync_q <= '1;
      for (int i = 0; i < SYNC_STAGES; i++) a_sync_q[i] <= 2'b11;
      fill_q    <= 2'd0;
      rd_hist_q <= 1'b1;
      wr_hist_q <= 1'b1;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.CS_n};
      rd_sync_q   <= {rd_sync_q[SYNC_STAGES-2:0], bus.RD_n};
      wr_sync_q   <= {wr_sync_q[SYNC_STAGES-2:0], bus.WR_n};
      a_sync_q[0] <= bus.A;
      for (int i = 1; i < SYNC_STAGES; i++) a_sync_q[i] <= a_sync_q[i-1];
      if (!fill_done) fill_q <= fill_q + 2'd1;
      rd_hist_q <= fill_done ? rd_act : 1'b1;
      wr_hist_q <= fill_done ? wr_act : 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    ta_d       = ta_q;
    sel_d      = sel_q;
    conflict_d = 1'b0;
    timeout_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rd_start && wr_start) begin
          conflict_d = 1'b1;
        end else if (wr_start) begin
          state_d = S_W_LATCH;
          sel_d   = a_s;
        end else if (rd_start) begin
          state_d = S_R_FETCH;
          sel_d   = a_s;
        end
      end
      S_W_LATCH: state_d = S_W_PUSH;
      S_W_PUSH: begin
        state_d = S_WAIT_REL;
        tmo_d   = 8'd0;
      end
      S_R_FETCH: begin
        state_d = S_R_DRIVE;
        tmo_d   = 8'd0;
      end
      S_WAIT_REL, S_R_DRIVE: begin
        // A release seen in the deadline cycle still counts as a clean release.
        if ((state_q == S_WAIT_REL) ? !wr_act : !rd_act) begin
          state_d = S_TURN;
          ta_d    = 4'd0;
        end else if (tmo_q == TMO_LAST) begin
          state_d   = S_TURN;
          ta_d      = 4'd0;
          timeout_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_TURN: begin
        if (ta_q == TA_LAST) state_d = S_IDLE;
        else                 ta_d    = ta_q + 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= S_IDLE;
      tmo_q          <= 8'd0;
      ta_q           <= 4'd0;
      sel_q          <= 2'd0;
      wr_q           <= 1'b0;
      ird_q          <= 1'b0;
      iwr_q          <= 1'b0;
      rd_q           <= 1'b0;
      reg_wr_en_q    <= 1'b0;
      reg_rd_en_q    <= 1'b0;
      busy_q         <= 1'b0;
      err_conflict_q <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      tmo_q          <= tmo_d;
      ta_q           <= ta_d;
      sel_q          <= sel_d;
      wr_q           <= (state_d == S_W_LATCH) || (state_d == S_R_FETCH);
      ird_q          <= (state_d == S_W_LATCH);
      iwr_q          <= (state_d == S_R_DRIVE);
      rd_q           <= (state_d == S_W_PUSH);
      reg_wr_en_q    <= (state_d == S_W_PUSH);
      reg_rd_en_q    <= (state_d == S_R_FETCH);
      busy_q         <= (state_d != S_IDLE);
      err_conflict_q <= conflict_d;
      err_timeout_q  <= timeout_d;
    end
  end

  assign bus.WR           = wr_q;
  assign bus.IRD          = ird_q;
  assign bus.IWR          = iwr_q;
  assign bus.RD           = rd_q;
  assign bus.reg_sel      = sel_q;
  assign bus.reg_wr_en    = reg_wr_en_q;
  assign bus.reg_rd_en    = reg_rd_en_q;
  assign bus.busy         = busy_q;
  assign bus.err_conflict = err_conflict_q;
  assign bus.err_timeout  = err_timeout_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_bus_rw_ctrl.sv
// Bench for bus_rw_ctrl: a driver issues CPU accesses and queues the predicted access
// summary; a negedge monitor rebuilds each access from the outputs and compares.
module tb_bus_rw_ctrl;
  localparam int SYNC = 2;
  localparam int TA   = 2;
  localparam int TMO  = 64;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bus_rw_ctrl_if bus ();
  logic [2:0] dbg_state;

  bus_rw_ctrl #(.SYNC_STAGES(SYNC), .TA_CYCLES(TA), .TIMEOUT(TMO)) dut (
    .CLK        (clk),
    .RST        (rst),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  typedef struct packed {
    logic [15:0] start_cyc;
    logic [7:0]  busy_len;
    logic [7:0]  iwr_len;
    logic [1:0]  wr_cnt;
    logic        ird_at_wr;
    logic [1:0]  reg_wr_cnt;
    logic [1:0]  reg_rd_cnt;
    logic [1:0]  tmo_cnt;
    logic [1:0]  conf_cnt;
    logic [1:0]  sel;
    logic [7:0]  rdata;
  } txn_t;
  localparam int W = $bits(txn_t);

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  logic [7:0] cpu_data;
  logic [7:0] exp_regs [4];
  logic [7:0] regs [4];
  logic [7:0] buf_q;
  logic [7:0] mon_ibus;
  bit         mon_en = 1'b0;
  bit         active = 1'b0;
  bit         mon_any;
  txn_t       act_t;

  task automatic check(string name, int got, int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference: an access becomes visible SYNC edges after its first low sample k; the
  // release is seen h+SYNC edges after k; each access has a minimum length and a deadline.
  function automatic txn_t model(int kind, logic [1:0] addr, int h, int k);
    txn_t t;
    int s, rel, early, dead, e;
    t = '0;
    s = k + SYNC;
    t.start_cyc = 16'(s);
    if (kind == 2) begin
      t.conf_cnt = 2'd1;
      return t;
    end
    rel      = k + h + SYNC;
    t.wr_cnt = 2'd1;
    t.sel    = addr;
    if (kind == 0) begin
      early        = s + 3;
      dead         = s + 2 + TMO;
      t.ird_at_wr  = 1'b1;
      t.reg_wr_cnt = 2'd1;
    end else begin
      early        = s + 2;
      dead         = s + 1 + TMO;
      t.reg_rd_cnt = 2'd1;
      t.rdata      = exp_regs[addr];
    end
    if (rel > dead) begin
      e         = dead;
      t.tmo_cnt = 2'd1;
    end else begin
      e = (rel > early) ? rel : early;
    end
    t.busy_len = 8'(e - s + TA);
    if (kind == 1) t.iwr_len = 8'(e - s - 1);
    return t;
  endfunction

  function automatic logic [1:0] sat(logic [1:0] v, logic b);
    return (b && v != 2'd3) ? v + 2'd1 : v;
  endfunction

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (i >= 4 && !bus.busy) done = 1'b1;
    end
    check("idle_wait", int'(done), 1);
  endtask

  // driver: kind 0 = write, 1 = read, 2 = read+write together
  task automatic do_txn(int kind, logic [1:0] addr, int h, logic [7:0] data);
    txn_t t;
    int   k;
    @(negedge clk);
    k = cyc + 1;
    t = model(kind, addr, h, k);
    exp_q.push_back(t);
    if (kind == 0) exp_regs[addr] = data;
    bus.A    = addr;
    cpu_data = data;
    bus.CS_n = 1'b0;
    bus.WR_n = (kind == 1);
    bus.RD_n = (kind == 0);
    repeat (h) @(negedge clk);
    bus.CS_n = 1'b1;
    bus.WR_n = 1'b1;
    bus.RD_n = 1'b1;
    wait_idle();
  endtask

  task automatic reset_mid_read(logic [1:0] addr);
    txn_t t;
    int   k, s, r;
    @(negedge clk);
    k = cyc + 1;
    s = k + SYNC;
    r = k + 6;
    t = model(1, addr, 200, k);
    t.busy_len = 8'(r - s);
    t.iwr_len  = 8'(r - s - 1);
    t.tmo_cnt  = 2'd0;
    exp_q.push_back(t);
    bus.A    = addr;
    bus.CS_n = 1'b0;
    bus.RD_n = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_iwr", int'(bus.IWR), 0);
    check("rst_mid_busy", int'(bus.busy), 0);
    check("rst_mid_state", int'(dbg_state), 0);
    check("rst_mid_errs", int'(bus.err_conflict | bus.err_timeout), 0);
    rst      = 1'b0;
    bus.CS_n = 1'b1;
    bus.RD_n = 1'b1;
    wait_idle();
  endtask

  task automatic compare_txn(txn_t a);
    txn_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_txn: got access at cycle %0d, expected none", a.start_cyc);
      return;
    end
    e = exp_q.pop_front();
    check("start_cyc",  int'(a.start_cyc),  int'(e.start_cyc));
    check("busy_len",   int'(a.busy_len),   int'(e.busy_len));
    check("iwr_len",    int'(a.iwr_len),    int'(e.iwr_len));
    check("wr_cnt",     int'(a.wr_cnt),     int'(e.wr_cnt));
    check("ird_at_wr",  int'(a.ird_at_wr),  int'(e.ird_at_wr));
    check("reg_wr_cnt", int'(a.reg_wr_cnt), int'(e.reg_wr_cnt));
    check("reg_rd_cnt", int'(a.reg_rd_cnt), int'(e.reg_rd_cnt));
    check("tmo_cnt",    int'(a.tmo_cnt),    int'(e.tmo_cnt));
    check("conf_cnt",   int'(a.conf_cnt),   int'(e.conf_cnt));
    check("reg_sel",    int'(a.sel),        int'(e.sel));
    check("read_data",  int'(a.rdata),      int'(e.rdata));
  endtask

  // monitor + buffer/register-file model driven by the DUT controls
  always @(negedge clk) begin
    if (mon_en) begin
      check("inv_iwr_rd", int'(bus.IWR & bus.RD), 0);
      check("inv_regwr_regrd", int'(bus.reg_wr_en & bus.reg_rd_en), 0);
      check("inv_wr_phase", int'(bus.WR & ~((bus.IRD & ~bus.reg_rd_en) | (~bus.IRD & bus.reg_rd_en))), 0);
      check("inv_busy_state", int'(bus.busy), int'(dbg_state != 3'd0));
      mon_ibus = bus.reg_rd_en ? regs[bus.reg_sel] : (bus.RD ? buf_q : 8'h00);
      mon_any  = bus.busy | bus.err_conflict | bus.err_timeout | bus.WR | bus.IWR |
                 bus.RD | bus.reg_wr_en | bus.reg_rd_en;
      if (!active && mon_any) begin
        active          = 1'b1;
        act_t           = '0;
        act_t.start_cyc = 16'(cyc);
      end
      if (active) begin
        act_t.busy_len   = act_t.busy_len + 8'(bus.busy);
        act_t.iwr_len    = act_t.iwr_len + 8'(bus.IWR);
        act_t.wr_cnt     = sat(act_t.wr_cnt, bus.WR);
        act_t.reg_wr_cnt = sat(act_t.reg_wr_cnt, bus.reg_wr_en);
        act_t.reg_rd_cnt = sat(act_t.reg_rd_cnt, bus.reg_rd_en);
        act_t.tmo_cnt    = sat(act_t.tmo_cnt, bus.err_timeout);
        act_t.conf_cnt   = sat(act_t.conf_cnt, bus.err_conflict);
        if (bus.WR) act_t.ird_at_wr = bus.IRD;
        if (bus.reg_wr_en || bus.reg_rd_en) act_t.sel = bus.reg_sel;
        if (bus.IWR) act_t.rdata = buf_q;
      end
      if (bus.WR) buf_q = bus.IRD ? cpu_data : mon_ibus;
      if (bus.reg_wr_en) regs[bus.reg_sel] = mon_ibus;
      if (active && !bus.busy) begin
        active = 1'b0;
        compare_txn(act_t);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected to finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, h;
    regs[0] = 8'h00; regs[1] = 8'h5A; regs[2] = 8'hC3; regs[3] = 8'h11;
    for (int i = 0; i < 4; i++) exp_regs[i] = regs[i];
    buf_q    = 8'h00;
    cpu_data = 8'h00;
    rst      = 1'b1;
    bus.CS_n = 1'b0;
    bus.WR_n = 1'b0;
    bus.RD_n = 1'b1;
    bus.A    = 2'b00;
    repeat (2) @(negedge clk);
    check("rst_wr",        int'(bus.WR), 0);
    check("rst_ird",       int'(bus.IRD), 0);
    check("rst_iwr",       int'(bus.IWR), 0);
    check("rst_rd",        int'(bus.RD), 0);
    check("rst_reg_sel",   int'(bus.reg_sel), 0);
    check("rst_reg_en",    int'(bus.reg_wr_en | bus.reg_rd_en), 0);
    check("rst_busy",      int'(bus.busy), 0);
    check("rst_errs",      int'(bus.err_conflict | bus.err_timeout), 0);
    check("rst_state",     int'(dbg_state), 0);
    mon_en = 1'b1;
    rst    = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_start_held_wr", int'(bus.busy), 0);
    end
    bus.CS_n = 1'b1;
    bus.WR_n = 1'b1;
    repeat (3) @(negedge clk);

    do_txn(0, 2'b10, 6, 8'hA7);
    do_txn(1, 2'b01, 8, 8'h00);
    do_txn(1, 2'b10, 3, 8'h00);
    do_txn(2, 2'b11, 5, 8'h00);
    do_txn(1, 2'b01, 100, 8'h00);
    do_txn(0, 2'b00, 80, 8'h3C);
    do_txn(0, 2'b11, 1, 8'hE1);
    do_txn(1, 2'b11, 1, 8'h00);
    reset_mid_read(2'b01);
    do_txn(1, 2'b01, 5, 8'h00);

    for (int n = 0; n < 30; n++) begin
      kind = $urandom_range(0, 2);
      h    = ($urandom_range(0, 7) == 0) ? $urandom_range(60, 75) : $urandom_range(1, 12);
      do_txn(kind, 2'($urandom_range(0, 3)), h, 8'($urandom_range(0, 255)));
    end

    repeat (3) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("monitor_closed", int'(active), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
